alu_operand_stage: RTL and testbench

//   Registered ALU operand-select stage between decode and execute. Resolves

---
 rtl/alu_pkg.sv | 16 +
 rtl/imm_extender.sv | 24 ++
 rtl/alu_operand_stage.sv | 158 +++++++++++++++
 tb/tb_alu_operand_stage.sv | 307 ++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/alu_pkg.sv
// Shared encodings for the ALU operand-select stage.
// Forward-select codes and skid-buffer occupancy states.
package alu_pkg;

   localparam logic [1:0] FWD_REG   = 2'b00;
   localparam logic [1:0] FWD_EXMEM = 2'b01;
   localparam logic [1:0] FWD_MEMWB = 2'b10;
   localparam logic [1:0] FWD_RSVD  = 2'b11;

   typedef enum logic [1:0] {
      OCC_EMPTY = 2'd0,
      OCC_ONE   = 2'd1,
      OCC_TWO   = 2'd2
   } occ_e;

endpackage

// File: rtl/imm_extender.sv
// Immediate extender: sign- or zero-extends a raw immediate.
// Ports: imm, imm_signed in; ext out. Purely combinational.
module imm_extender #(
   parameter int IMM_WIDTH      = 4,
   parameter int REG_DATA_WIDTH = 16
) (
   input  logic [IMM_WIDTH-1:0]      imm,
   input  logic                      imm_signed,
   output logic [REG_DATA_WIDTH-1:0] ext
);

   generate
      if (IMM_WIDTH == REG_DATA_WIDTH) begin : g_pass
         logic unused_sgn;
         assign unused_sgn = imm_signed;
         assign ext = imm;
      end else begin : g_ext
         logic fill;
         assign fill = imm_signed & imm[IMM_WIDTH-1];
         assign ext = {{(REG_DATA_WIDTH-IMM_WIDTH){fill}}, imm};
      end
   endgenerate

endmodule

// File: rtl/alu_operand_stage.sv
// Registered ALU operand-select stage with forwarding, imm extension
// and a 2-entry skid buffer. Ports: valid/ready in and out, flush,
// rs1/rs2/imm/forward sources in; op_a, op_b, store_data out.
module alu_operand_stage
   import alu_pkg::*;
#(
   parameter int REG_DATA_WIDTH = 16,
   parameter int IMM_WIDTH      = 4
) (
   input  logic                      clk,
   input  logic                      rst,
   input  logic                      in_valid,
   output logic                      in_ready,
   input  logic [REG_DATA_WIDTH-1:0] rs1_data,
   input  logic [REG_DATA_WIDTH-1:0] rs2_data,
   input  logic [IMM_WIDTH-1:0]      imm,
   input  logic                      imm_signed,
   input  logic                      alu_src,
   input  logic [1:0]                fwd_a_sel,
   input  logic [1:0]                fwd_b_sel,
   input  logic [REG_DATA_WIDTH-1:0] exmem_data,
   input  logic [REG_DATA_WIDTH-1:0] memwb_data,
   input  logic                      flush,
   output logic                      out_valid,
   input  logic                      out_ready,
   output logic [REG_DATA_WIDTH-1:0] op_a,
   output logic [REG_DATA_WIDTH-1:0] op_b,
   output logic [REG_DATA_WIDTH-1:0] store_data
);

   typedef struct packed {
      logic [REG_DATA_WIDTH-1:0] a;
      logic [REG_DATA_WIDTH-1:0] b;
      logic [REG_DATA_WIDTH-1:0] sd;
   } opnd_t;

   logic [REG_DATA_WIDTH-1:0] imm_ext;
   logic [REG_DATA_WIDTH-1:0] fwd_a;
   logic [REG_DATA_WIDTH-1:0] fwd_b;
   opnd_t in_bndl;
   opnd_t out_q;
   opnd_t skid_q;

   occ_e state;
   occ_e state_nxt;
   logic in_ready_q;
   logic accept;
   logic xfer;
   logic load_out;
   logic load_skid;
   logic skid_to_out;

   imm_extender #(
      .IMM_WIDTH      (IMM_WIDTH),
      .REG_DATA_WIDTH (REG_DATA_WIDTH)
   ) u_imm_ext (
      .imm        (imm),
      .imm_signed (imm_signed),
      .ext        (imm_ext)
   );

   // FWD_RSVD falls into default and selects the register value.
   always_comb begin
      fwd_a = rs1_data;
      unique case (1'b1)
         (fwd_a_sel == FWD_EXMEM): fwd_a = exmem_data;
         (fwd_a_sel == FWD_MEMWB): fwd_a = memwb_data;
         default:                  fwd_a = rs1_data;
      endcase
   end

   always_comb begin
      fwd_b = rs2_data;
      unique case (1'b1)
         (fwd_b_sel == FWD_EXMEM): fwd_b = exmem_data;
         (fwd_b_sel == FWD_MEMWB): fwd_b = memwb_data;
         default:                  fwd_b = rs2_data;
      endcase
   end

   always_comb begin
      in_bndl    = '0;
      in_bndl.a  = fwd_a;
      in_bndl.b  = alu_src ? imm_ext : fwd_b;
      in_bndl.sd = fwd_b;
   end

   assign accept = in_valid && in_ready_q;
   assign xfer   = out_valid && out_ready;

   always_ff @(posedge clk) begin
      if (!rst) begin
         state      <= OCC_EMPTY;
         in_ready_q <= 1'b1;
      end else begin
         state      <= state_nxt;
         in_ready_q <= (state_nxt != OCC_TWO);
      end
   end

   always_comb begin
      state_nxt = state;
      if (flush) begin
         state_nxt = OCC_EMPTY;
      end else begin
         unique case (state)
            OCC_EMPTY: if (accept) state_nxt = OCC_ONE;
            OCC_ONE: begin
               if (accept && !xfer)
                  state_nxt = OCC_TWO;
               else if (!accept && xfer)
                  state_nxt = OCC_EMPTY;
            end
            OCC_TWO: if (xfer) state_nxt = OCC_ONE;
            default: state_nxt = OCC_EMPTY;
         endcase
      end
   end

   // A flushed cycle loads nothing; held data is left in place.
   always_comb begin
      out_valid   = (state != OCC_EMPTY);
      load_out    = 1'b0;
      load_skid   = 1'b0;
      skid_to_out = 1'b0;
      if (!flush) begin
         unique case (state)
            OCC_EMPTY: load_out = accept;
            OCC_ONE: begin
               load_out  = accept && xfer;
               load_skid = accept && !xfer;
            end
            OCC_TWO: skid_to_out = xfer;
            default: ;
         endcase
      end
   end

   always_ff @(posedge clk) begin
      if (!rst) begin
         out_q  <= '0;
         skid_q <= '0;
      end else begin
         if (load_out)
            out_q <= in_bndl;
         else if (skid_to_out)
            out_q <= skid_q;
         if (load_skid)
            skid_q <= in_bndl;
      end
   end

   assign in_ready   = in_ready_q;
   assign op_a       = out_q.a;
   assign op_b       = out_q.b;
   assign store_data = out_q.sd;

endmodule

// File: tb/tb_alu_operand_stage.sv
// Scoreboard bench for alu_operand_stage.
// Directed scenarios followed by a randomized stream.
module tb_alu_operand_stage;

   localparam int W  = 16;
   localparam int IW = 4;

   logic          clk = 1'b0;
   logic          rst;
   logic          in_valid;
   logic          in_ready;
   logic [W-1:0]  rs1_data;
   logic [W-1:0]  rs2_data;
   logic [IW-1:0] imm;
   logic          imm_signed;
   logic          alu_src;
   logic [1:0]    fwd_a_sel;
   logic [1:0]    fwd_b_sel;
   logic [W-1:0]  exmem_data;
   logic [W-1:0]  memwb_data;
   logic          flush;
   logic          out_valid;
   logic          out_ready;
   logic [W-1:0]  op_a;
   logic [W-1:0]  op_b;
   logic [W-1:0]  store_data;

   always #5 clk = ~clk;

   alu_operand_stage #(
      .REG_DATA_WIDTH (W),
      .IMM_WIDTH      (IW)
   ) dut (
      .clk        (clk),
      .rst        (rst),
      .in_valid   (in_valid),
      .in_ready   (in_ready),
      .rs1_data   (rs1_data),
      .rs2_data   (rs2_data),
      .imm        (imm),
      .imm_signed (imm_signed),
      .alu_src    (alu_src),
      .fwd_a_sel  (fwd_a_sel),
      .fwd_b_sel  (fwd_b_sel),
      .exmem_data (exmem_data),
      .memwb_data (memwb_data),
      .flush      (flush),
      .out_valid  (out_valid),
      .out_ready  (out_ready),
      .op_a       (op_a),
      .op_b       (op_b),
      .store_data (store_data)
   );

   typedef struct {
      logic [W-1:0] a;
      logic [W-1:0] b;
      logic [W-1:0] s;
   } exp_t;

   exp_t sbq[$];
   exp_t mon_e;
   int   checks   = 0;
   int   failures = 0;
   bit   started  = 1'b0;
   bit   acc;

   task automatic chk(input string nm, input logic [W-1:0] act,
                      input logic [W-1:0] want);
      checks++;
      if (act !== want) begin
         failures++;
         $display("FAIL %s: got %h want %h", nm, act, want);
      end
   endtask

   task automatic chkb(input string nm, input logic act, input logic want);
      checks++;
      if (act !== want) begin
         failures++;
         $display("FAIL %s: got %b want %b", nm, act, want);
      end
   endtask

   function automatic logic [W-1:0] pick(input logic [1:0] s,
      input logic [W-1:0] r, input logic [W-1:0] ex,
      input logic [W-1:0] mw);
      if (s == 2'd1) return ex;
      if (s == 2'd2) return mw;
      return r;
   endfunction

   function automatic logic [W-1:0] ext_model(input logic [IW-1:0] v,
                                              input logic sg);
      int x;
      x = int'(v);
      if (sg && x >= (1 << (IW - 1)))
         x = x - (1 << IW);
      return W'(x);
   endfunction

   function automatic exp_t model();
      exp_t e;
      e.a = pick(fwd_a_sel, rs1_data, exmem_data, memwb_data);
      e.s = pick(fwd_b_sel, rs2_data, exmem_data, memwb_data);
      e.b = alu_src ? ext_model(imm, imm_signed) : e.s;
      return e;
   endfunction

   // Occupancy is checked against the scoreboard depth, then any
   // accepted bundle is recorded, then one clock elapses.
   task automatic tick(output bit a);
      a = 1'b0;
      if (started) begin
         chkb("out_valid_occ", out_valid, sbq.size() != 0);
         chkb("in_ready_occ", in_ready, sbq.size() < 2);
      end
      if (rst && in_valid && in_ready && !flush) begin
         a = 1'b1;
         sbq.push_back(model());
      end
      @(posedge clk);
      #1;
      started = 1'b1;
   endtask

   task automatic rand_data();
      rs1_data   = W'($urandom);
      rs2_data   = W'($urandom);
      imm        = IW'($urandom);
      imm_signed = 1'($urandom);
      alu_src    = 1'($urandom);
      fwd_a_sel  = 2'($urandom);
      fwd_b_sel  = 2'($urandom);
      exmem_data = W'($urandom);
      memwb_data = W'($urandom);
   endtask

   always @(negedge clk) begin
      if (!rst) begin
         sbq.delete();
      end else begin
         if (out_valid && out_ready) begin
            if (sbq.size() == 0) begin
               checks++;
               failures++;
               $display("FAIL spurious_out: got op_a %h want none", op_a);
            end else begin
               mon_e = sbq.pop_front();
               chk("mon_op_a", op_a, mon_e.a);
               chk("mon_op_b", op_b, mon_e.b);
               chk("mon_store", store_data, mon_e.s);
            end
         end
         if (flush)
            sbq.delete();
      end
   end

   initial begin
      rst = 1'b0;
      in_valid = 1'b0;
      out_ready = 1'b0;
      flush = 1'b0;
      rs1_data = '0;
      rs2_data = '0;
      imm = '0;
      imm_signed = 1'b0;
      alu_src = 1'b0;
      fwd_a_sel = 2'b00;
      fwd_b_sel = 2'b00;
      exmem_data = '0;
      memwb_data = '0;

      // reset
      tick(acc);
      tick(acc);
      chkb("rst_out_valid", out_valid, 1'b0);
      chkb("rst_in_ready", in_ready, 1'b1);
      chk("rst_op_a", op_a, 16'h0000);
      chk("rst_op_b", op_b, 16'h0000);
      chk("rst_store", store_data, 16'h0000);
      rst = 1'b1;

      // immediate extension
      out_ready = 1'b1;
      in_valid = 1'b1;
      rs1_data = 16'h0005;
      rs2_data = 16'h0C0C;
      imm = 4'hA;
      imm_signed = 1'b1;
      alu_src = 1'b1;
      tick(acc);
      chkb("imm_acc", acc, 1'b1);
      chk("imm_op_a", op_a, 16'h0005);
      chk("imm_sext", op_b, 16'hFFFA);
      chk("imm_store", store_data, 16'h0C0C);
      imm_signed = 1'b0;
      tick(acc);
      chk("imm_zext", op_b, 16'h000A);

      // forwarding
      exmem_data = 16'h1234;
      memwb_data = 16'h5678;
      fwd_a_sel = 2'b01;
      fwd_b_sel = 2'b10;
      alu_src = 1'b0;
      tick(acc);
      chk("fwd_op_a", op_a, 16'h1234);
      chk("fwd_op_b", op_b, 16'h5678);
      chk("fwd_store", store_data, 16'h5678);
      fwd_a_sel = 2'b11;
      rs1_data = 16'h0BEE;
      tick(acc);
      chk("fwd_rsvd", op_a, 16'h0BEE);
      in_valid = 1'b0;
      tick(acc);

      // stall and skid
      out_ready = 1'b0;
      fwd_a_sel = 2'b00;
      fwd_b_sel = 2'b01;
      in_valid = 1'b1;
      rs1_data = 16'h1111;
      tick(acc);
      chkb("b1_acc", acc, 1'b1);
      rs1_data = 16'h2222;
      tick(acc);
      chkb("b2_acc", acc, 1'b1);
      rs1_data = 16'h3333;
      tick(acc);
      chkb("b3_blocked", acc, 1'b0);
      chk("stall_op_a", op_a, 16'h1111);
      exmem_data = 16'hDEAD;
      tick(acc);
      chk("stall_hold", op_a, 16'h1111);
      chk("stall_sd", store_data, 16'h1234);
      out_ready = 1'b1;
      for (int i = 0; i < 3; i++) begin
         chkb("nogap_valid", out_valid, 1'b1);
         chk("order_op_a", op_a, W'(16'h1111 * (i + 1)));
         tick(acc);
         if (acc)
            in_valid = 1'b0;
      end
      in_valid = 1'b0;
      tick(acc);

      // flush from TWO
      out_ready = 1'b0;
      in_valid = 1'b1;
      rand_data();
      tick(acc);
      rand_data();
      tick(acc);
      flush = 1'b1;
      rand_data();
      tick(acc);
      flush = 1'b0;
      in_valid = 1'b0;
      chkb("flush_valid", out_valid, 1'b0);
      chkb("flush_ready", in_ready, 1'b1);
      out_ready = 1'b1;
      tick(acc);
      tick(acc);

      // reset in TWO
      out_ready = 1'b0;
      in_valid = 1'b1;
      rand_data();
      tick(acc);
      rand_data();
      tick(acc);
      rst = 1'b0;
      tick(acc);
      rst = 1'b1;
      in_valid = 1'b0;
      chkb("rst2_valid", out_valid, 1'b0);
      chkb("rst2_ready", in_ready, 1'b1);
      chk("rst2_op_a", op_a, 16'h0000);
      chk("rst2_op_b", op_b, 16'h0000);
      chk("rst2_store", store_data, 16'h0000);

      // random stream
      for (int n = 0; n < 500; n++) begin
         rand_data();
         in_valid  = ($urandom % 4) != 0;
         out_ready = ($urandom % 3) != 0;
         flush     = ($urandom % 25) == 0;
         rst       = ($urandom % 97) != 0;
         tick(acc);
      end

      // drain
      rst = 1'b1;
      flush = 1'b0;
      in_valid = 1'b0;
      out_ready = 1'b1;
      for (int n = 0; n < 4; n++)
         tick(acc);
      chk("drain_empty", W'(sbq.size()), 16'h0000);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
